// File: rtl/rr_grant_arbiter8_if.sv
// Bundles the requester-facing handshake of the 8-way round-robin arbiter.
// Latency: none, wires only.
// Backpressure: none; req is held by each requester until it no longer wants the resource.
//
// Signals:
//   req     requester -> arbiter  8  per-requester request, held while ownership is wanted
//   mask    requester -> arbiter  8  per-requester enable; eligible only when req & mask
//   gnt     arbiter -> requester  8  registered one-hot grant, zero when there is no owner
//   gnt_id  arbiter -> requester  3  index of the current owner, meaningful while gnt_vld
//   gnt_vld arbiter -> requester  1  high while any grant line is asserted
//   preempt arbiter -> requester  1  one-cycle pulse after an owner is forcibly removed
//   busy    arbiter -> requester  1  high whenever the arbiter is not idle
interface rr_grant_arbiter8_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       preempt;
    logic       busy;

    // Requester side drives req/mask and observes the grant.
    modport master (
        output req, mask,
        input  gnt, gnt_id, gnt_vld, preempt, busy
    );

    // Arbiter side.
    modport slave (
        input  req, mask,
        output gnt, gnt_id, gnt_vld, preempt, busy
    );
endinterface

// File: rtl/rr_grant_arbiter8.sv
// 8-way round-robin arbiter with lock-until-release, max-hold preemption and a dead gap between owners.
// Latency: eligible request before edge n gives a registered grant after edge n.
// Backpressure: owner keeps the grant while requesting; others wait, and may preempt only after MAX_HOLD cycles.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_grant_arbiter8_if.slave: req/mask in, gnt/gnt_id/gnt_vld/preempt/busy out
module rr_grant_arbiter8 #(
    parameter int unsigned MAX_HOLD   = 16,   // 1..255
    parameter int unsigned GAP_CYCLES = 1     // 1..15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_grant_arbiter8_if.slave   bus
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    localparam logic [3:0] GAP_C      = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       gnt_vld_q, gnt_vld_d;
    logic       preempt_q, preempt_d;
    logic       busy_q, busy_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [2:0] last_q, last_d;

    logic [7:0] elig;
    logic       win_found;
    logic [2:0] win_id;
    logic [2:0] cand;

    assign elig = bus.req & bus.mask;

    // Rotating priority search: start just after the last owner and wrap.
    // The eighth candidate is last_q itself, so a lone previous owner can still win.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        cand      = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            cand = last_q + 3'(i);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        gnt_vld_d  = gnt_vld_q;
        preempt_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        last_d     = last_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = GRANT;
                    gnt_id_d   = win_id;
                    gnt_d      = 8'h01 << win_id;
                    gnt_vld_d  = 1'b1;
                    hold_cnt_d = 8'd1;
                end
            end

            GRANT: begin
                // A dropped request or cleared mask is a release and takes
                // priority over preemption, so preempt stays low in that case.
                if (!elig[gnt_id_q] ||
                    ((hold_cnt_q == MAX_HOLD_C) && ((elig & ~gnt_q) != 8'h00))) begin
                    state_d   = GAP;
                    gnt_d     = 8'h00;
                    gnt_vld_d = 1'b0;
                    last_d    = gnt_id_q;
                    gap_cnt_d = 4'd1;
                    preempt_d = elig[gnt_id_q];
                end else if (hold_cnt_q != MAX_HOLD_C) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end

            GAP: begin
                if (gap_cnt_q >= GAP_C) begin
                    if (win_found) begin
                        state_d    = GRANT;
                        gnt_id_d   = win_id;
                        gnt_d      = 8'h01 << win_id;
                        gnt_vld_d  = 1'b1;
                        hold_cnt_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d   = IDLE;
                gnt_d     = 8'h00;
                gnt_vld_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 8'h00;
            gnt_id_q   <= 3'd0;
            gnt_vld_q  <= 1'b0;
            preempt_q  <= 1'b0;
            busy_q     <= 1'b0;
            hold_cnt_q <= 8'd0;
            gap_cnt_q  <= 4'd0;
            last_q     <= 3'd7;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_vld_q  <= gnt_vld_d;
            preempt_q  <= preempt_d;
            busy_q     <= busy_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            last_q     <= last_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.preempt = preempt_q;
    assign bus.busy    = busy_q;

endmodule

// File: doc/rr_grant_arbiter8.md
Name: rr_grant_arbiter8

Overview:
- 8-way round-robin arbiter that shares one resource, a bus or chip-select fabric, between eight requesters.
- Encodes the winner as a 3-bit index and drives the matching one-hot grant line, so it is the sequencing controller in front of the 3-to-8 select decode.
- Supports lock-until-release, a maximum-hold preemption timer and a dead cycle between owners.

Parameters:
- MAX_HOLD, 16, grant cycles before the owner can be preempted if another requester is waiting (legal 1..255).
- GAP_CYCLES, 1, idle turnaround cycles with no grant between owners (legal 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  per-requester request; held high while ownership is wanted.
- mask  input  8  per-requester enable; a requester is eligible only when req[i] & mask[i].
- gnt  output  8  registered one-hot grant; all zero when no owner.
- gnt_id  output  3  registered index of the current owner; valid only when gnt_vld=1.
- gnt_vld  output  1  high while any grant is asserted.
- preempt  output  1  one-cycle pulse on the cycle after the owner is forcibly removed.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync-released use): gnt=0, gnt_id=0, gnt_vld=0, preempt=0, busy=0, state=IDLE, hold_cnt=0, gap_cnt=0, last=7. Requester 0 has first priority after reset.
- elig = req & mask, sampled each rising edge.
- Arbitration search:
  - Start at (last+1) mod 8, ascending with wrap at 7→0; the first set bit of elig wins.
  - Pure combinational priority rotate; the result is registered.
- State IDLE:
  - If elig != 0: register winner into gnt_id, gnt = one-hot(gnt_id), gnt_vld=1, hold_cnt=1, go GRANT.
  - Latency: req high before edge n gives gnt high after edge n (one cycle).
- State GRANT (owner = gnt_id):
  - Release: elig[owner]==0, whether from req drop or mask clear. Next edge: gnt=0, gnt_vld=0, last=owner, gap_cnt=1, go GAP.
  - Preempt: hold_cnt==MAX_HOLD and (elig & ~one-hot(owner)) != 0. Next edge: same as release, plus preempt=1 for exactly one cycle.
  - Release and preempt true together: treat as release; preempt stays 0.
  - Otherwise: keep grant. hold_cnt increments and saturates at MAX_HOLD. A sole requester keeps the grant indefinitely past MAX_HOLD.
- State GAP:
  - gnt=0 for exactly GAP_CYCLES cycles; gap_cnt counts 1..GAP_CYCLES.
  - On the edge ending the last gap cycle: arbitrate as in IDLE. If elig!=0, go GRANT with the new owner. If elig==0, go IDLE.
  - The previous owner re-requesting during GAP gets lowest priority, because last=owner.
- Outputs:
  - gnt is always zero or exactly one-hot and equals decode(gnt_id) when gnt_vld=1.
  - No two owners in any cycle; at least GAP_CYCLES zero-grant cycles between consecutive grants.
- busy = (state != IDLE), registered with the state.
- mask changes take effect on the next edge like req; masking the owner is a release, not a preempt.
- Reset mid-grant: all outputs drop immediately (async), and last returns to 7.
- X on req/mask is not supported; the bench must drive known values.

Test Plan:
- Single requester: req=8'h10 held 5 cycles then dropped. Expect gnt=8'h10, gnt_id=4 one cycle after req, held 5 cycles, then 1 gap cycle with gnt=0, then IDLE with busy=0.
- All requesters, each drops req after 2 grant cycles then re-raises: grant order 0,1,2,…,7,0 with a 1-cycle gap between owners and no preempt pulses.
- Preemption, MAX_HOLD=4: req[2] and req[5] held high continuously.
  - Expect owner 2 for 4 cycles, preempt=1 once, gap, then owner 5 for 4 cycles, preempt, then owner 2.
  - With only req[2] high, owner 2 holds beyond 4 cycles and preempt stays 0.
- Masking: req=8'hFF, mask=8'b1010_0000. Expect only ids 5 and 7 to alternate. Clearing mask[owner] mid-grant causes a release with preempt=0.
- Reset mid-grant: assert rst_n=0 while gnt=8'h08. Expect gnt, gnt_vld, busy and preempt at 0 without a clock edge. After release with req=8'h88, the first owner is 3 (search from 0).
- Gap rotation, GAP_CYCLES=3: owner 6 releases and re-requests immediately while req[1] is high. Expect 3 zero-grant cycles, then owner 1, and owner 6 only after 1 releases.
